mandala_anim_sequencer: RTL

Frame-rate animation scheduler for the mandala VGA renderer. It runs in the pixel `clk` domain, detects frame boundaries from the sync generator's `vsync`, and sequences the renderer's animation state once per step: pattern phase, palette base and layer-enable mask. All outputs change only at a frame boundary, so the renderer never tears mid-frame. Board inputs provide pause, single-step and speed control.

---
 rtl/mandala_anim_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mandala_anim_sequencer.sv
// -----------------------------------------------------------------------------
// mandala_anim_sequencer
//
// Frame-rate animation scheduler for the mandala VGA renderer. Detects frame
// boundaries from vsync and, once per animation step, advances the pattern
// phase, the palette base colour and the ring-layer enable mask. Every output
// changes only on the clock edge that raises frame_tick, so the renderer
// never sees a change mid-frame.
//
// Optional feature macro: MANDALA_SEQ_AUTOCYCLE_EN
//   defined   : the GROW / HOLD / SHRINK scene FSM drives layer_mask and scene.
//   undefined : layer_mask is fixed at 8'hFF and scene is fixed at HOLD.
//
// Parameters
//   VSYNC_ACTIVE_HIGH : vsync polarity (0 = active-low)
//   HOLD_STEPS        : advances spent in HOLD, 1..255
//
// Ports
//   clk           in   pixel clock
//   rst_n         in   synchronous active-low reset
//   vsync         in   vertical sync, same clock domain
//   pause         in   level, freezes automatic advance
//   step          in   level, rising edge while paused requests one advance
//   speed[1:0]    in   advance period: 0=8 frames, 1=4, 2=2, 3=1
//   frame_tick    out  one-cycle pulse per frame boundary
//   pattern_phase out  8-bit angle offset
//   palette_base  out  6-bit {R,G,B} base colour (color_cnt[7:2])
//   layer_mask    out  bit i enables ring layer i+1
//   scene         out  GROW=0, HOLD=1, SHRINK=2
// -----------------------------------------------------------------------------
module mandala_anim_sequencer #(
  parameter bit VSYNC_ACTIVE_HIGH = 1'b0,
  parameter int HOLD_STEPS        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] speed,
  output logic       frame_tick,
  output logic [7:0] pattern_phase,
  output logic [5:0] palette_base,
  output logic [7:0] layer_mask,
  output logic [1:0] scene
);

  typedef enum logic [1:0] {
    SCENE_GROW   = 2'd0,
    SCENE_HOLD   = 2'd1,
    SCENE_SHRINK = 2'd2
  } scene_e;

  // Elaboration-time guard on the hold length.
  if ((HOLD_STEPS < 1) || (HOLD_STEPS > 255)) begin : g_hold_range_bad
    $error("HOLD_STEPS must be within 1..255");
  end

  logic       vs_norm_s;
  logic       vs_q_r;
  logic       vs_qq_r;
  logic       edge_s;
  logic       step_q_r;
  logic       step_rise_s;
  logic [2:0] pres_r;
  logic [2:0] pres_last_s;
  logic       step_pend_r;
  logic       advance_s;
  logic [7:0] color_cnt_r;

  // Frame-edge detect, step-edge detect, prescaler terminal count and the
  // single advance strobe shared by every piece of animation state.
  always_comb begin
    if (VSYNC_ACTIVE_HIGH) begin
      vs_norm_s = vsync;
    end else begin
      vs_norm_s = ~vsync;
    end

    edge_s      = vs_q_r & ~vs_qq_r;
    step_rise_s = step & ~step_q_r;

    // Terminal value P-1 for P = 8 >> speed.
    case (speed)
      2'd0:    pres_last_s = 3'd7;
      2'd1:    pres_last_s = 3'd3;
      2'd2:    pres_last_s = 3'd1;
      2'd3:    pres_last_s = 3'd0;
      default: pres_last_s = 3'd7;
    endcase

    advance_s = 1'b0;
    if (edge_s) begin
      if (pause) begin
        advance_s = step_pend_r;
      end else begin
        // >= rather than == so a period shortened mid-count still fires.
        advance_s = (pres_r >= pres_last_s);
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // Sync pipeline, prescaler, step request and phase/colour counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q_r        <= 1'b0;
      vs_qq_r       <= 1'b0;
      frame_tick    <= 1'b0;
      step_q_r      <= 1'b0;
      pres_r        <= 3'd0;
      step_pend_r   <= 1'b0;
      pattern_phase <= 8'd0;
      color_cnt_r   <= 8'd0;
    end else begin
      vs_q_r     <= vs_norm_s;
      vs_qq_r    <= vs_q_r;
      frame_tick <= edge_s;
      step_q_r   <= step;

      // Prescaler only runs on unpaused frame boundaries; it holds while paused.
      if (edge_s && !pause) begin
        if (pres_r >= pres_last_s) begin
          pres_r <= 3'd0;
        end else begin
          pres_r <= pres_r + 3'd1;
        end
      end

      // A fresh step edge wins over consumption so it is never lost.
      if (!pause) begin
        step_pend_r <= 1'b0;
      end else if (step_rise_s) begin
        step_pend_r <= 1'b1;
      end else if (edge_s) begin
        step_pend_r <= 1'b0;
      end

      if (advance_s) begin
        pattern_phase <= pattern_phase + 8'd1;
        color_cnt_r   <= color_cnt_r + 8'd1;
      end
    end
  end

  assign palette_base = color_cnt_r[7:2];

`ifdef MANDALA_SEQ_AUTOCYCLE_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_STEPS - 1);

  scene_e     scene_r;
  logic [7:0] mask_r;
  logic [7:0] hold_cnt_r;

  // Scene FSM: grow the ring mask to full, hold for HOLD_STEPS advances,
  // shrink back to the centre ring, repeat. Moves only on an advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scene_r    <= SCENE_GROW;
      mask_r     <= 8'h01;
      hold_cnt_r <= 8'd0;
    end else if (advance_s) begin
      case (scene_r)
        SCENE_GROW: begin
          mask_r <= {mask_r[6:0], 1'b1};
          if ({mask_r[6:0], 1'b1} == 8'hFF) begin
            scene_r    <= SCENE_HOLD;
            hold_cnt_r <= 8'd0;
          end
        end
        SCENE_HOLD: begin
          hold_cnt_r <= hold_cnt_r + 8'd1;
          if (hold_cnt_r >= HOLD_LAST) begin
            scene_r <= SCENE_SHRINK;
          end
        end
        SCENE_SHRINK: begin
          mask_r <= mask_r >> 1;
          if ((mask_r >> 1) == 8'h01) begin
            scene_r <= SCENE_GROW;
          end
        end
        default: begin
          scene_r    <= SCENE_GROW;
          mask_r     <= 8'h01;
          hold_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign layer_mask = mask_r;
  assign scene      = scene_r;
`else
  assign layer_mask = 8'hFF;
  assign scene      = SCENE_HOLD;
`endif

endmodule
